// File: rtl/motion_vector_select_pkg.sv
// Shared constants and FSM encoding for the motion-vector selector and its SAE stage.
package motion_vector_select_pkg;

  localparam int MVS_SEARCH_RANGE = 8;
  localparam int SAE_WIDTH        = 16;
  localparam int MV_W             = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } mvs_state_e;

endpackage

// File: rtl/motion_vector_select_mv_raster_counter.sv
// Raster x/y candidate counter over -R..+R with a last-candidate flag.
module mv_raster_counter
  import motion_vector_select_pkg::*;
#(
  parameter int RANGE = MVS_SEARCH_RANGE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic                   adv_i,
  output logic signed [MV_W-1:0] x_o,
  output logic signed [MV_W-1:0] y_o,
  output logic                   last_o
);

  localparam logic signed [MV_W-1:0] NEG_R = MV_W'(-RANGE);
  localparam logic signed [MV_W-1:0] POS_R = MV_W'(RANGE);

  logic signed [MV_W-1:0] x_q, x_d;
  logic signed [MV_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load_i) begin
      x_d = NEG_R;
      y_d = NEG_R;
    end else if (adv_i) begin
      if (x_q == POS_R) begin
        x_d = NEG_R;
        y_d = (y_q == POS_R) ? NEG_R : y_q + 8'sd1;
      end else begin
        x_d = x_q + 8'sd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == POS_R) && (y_q == POS_R);

endmodule

// File: rtl/motion_vector_select.sv
// Full-search minimum-SAE picker: walks the candidate window in raster order and
// reports the offset of the first candidate holding the lowest SAE.
//
//   state     | meaning
//   ST_IDLE   | waiting for i_start; results held
//   ST_SEARCH | accepting one SAE per valid beat
//   ST_DONE   | one-cycle o_done pulse, then back to idle
module motion_vector_select
  import motion_vector_select_pkg::*;
#(
  parameter int SEARCH_RANGE = MVS_SEARCH_RANGE,
  parameter int SAE_W        = SAE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_sae_valid,
  input  logic [SAE_W-1:0]       i_sae_result,
  output logic                   o_busy,
  output logic signed [MV_W-1:0] o_cand_x,
  output logic signed [MV_W-1:0] o_cand_y,
  output logic                   o_done,
  output logic [SAE_W-1:0]       o_best_sae,
  output logic signed [MV_W-1:0] o_mv_x,
  output logic signed [MV_W-1:0] o_mv_y
);

  localparam logic signed [MV_W-1:0] NEG_R = MV_W'(-SEARCH_RANGE);

  mvs_state_e             state_q, state_d;
  logic [SAE_W-1:0]       best_q, best_d;
  logic signed [MV_W-1:0] mv_x_q, mv_x_d;
  logic signed [MV_W-1:0] mv_y_q, mv_y_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;

  logic                   cnt_load;
  logic                   accept;
  logic                   cand_last;
  logic signed [MV_W-1:0] cand_x;
  logic signed [MV_W-1:0] cand_y;

  assign cnt_load = (state_q == ST_IDLE) && i_start;
  assign accept   = (state_q == ST_SEARCH) && i_sae_valid;

  mv_raster_counter #(
    .RANGE(SEARCH_RANGE)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load_i(cnt_load),
    .adv_i (accept),
    .x_o   (cand_x),
    .y_o   (cand_y),
    .last_o(cand_last)
  );

  always_comb begin
    state_d = state_q;
    best_d  = best_q;
    mv_x_d  = mv_x_q;
    mv_y_d  = mv_y_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_SEARCH;
          best_d  = '1;
          mv_x_d  = NEG_R;
          mv_y_d  = NEG_R;
          busy_d  = 1'b1;
        end
      end
      ST_SEARCH: begin
        if (i_sae_valid) begin
          // strict compare keeps the earliest candidate on ties
          if (i_sae_result < best_q) begin
            best_d = i_sae_result;
            mv_x_d = cand_x;
            mv_y_d = cand_y;
          end
          if (cand_last) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      best_q  <= '0;
      mv_x_q  <= '0;
      mv_y_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      best_q  <= best_d;
      mv_x_q  <= mv_x_d;
      mv_y_q  <= mv_y_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_best_sae = best_q;
  assign o_mv_x     = mv_x_q;
  assign o_mv_y     = mv_y_q;
  assign o_cand_x   = cand_x;
  assign o_cand_y   = cand_y;

endmodule

// File: tb/tb_motion_vector_select.sv
// Bench for motion_vector_select at R=1: fixed vector table, reset/ignore sequences, random searches.
module tb_motion_vector_select;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_start;
  logic               i_sae_valid;
  logic [15:0]        i_sae_result;
  logic               o_busy;
  logic signed [7:0]  o_cand_x, o_cand_y;
  logic               o_done;
  logic [15:0]        o_best_sae;
  logic signed [7:0]  o_mv_x, o_mv_y;

  int checks = 0;
  int errors = 0;

  motion_vector_select #(.SEARCH_RANGE(1), .SAE_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_sae_valid (i_sae_valid),
    .i_sae_result(i_sae_result),
    .o_busy      (o_busy),
    .o_cand_x    (o_cand_x),
    .o_cand_y    (o_cand_y),
    .o_done      (o_done),
    .o_best_sae  (o_best_sae),
    .o_mv_x      (o_mv_x),
    .o_mv_y      (o_mv_y)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0][15:0] sae;
    logic             gaps;
    logic [3:0]       start_at;   // 15 = no stray start pulse
    logic [15:0]      exp_best;
    logic signed [7:0] exp_x;
    logic signed [7:0] exp_y;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: first arg-min over raster-ordered candidates, starting from an all-ones best.
  task automatic model(input logic [8:0][15:0] s, output logic [15:0] b,
                       output int mx, output int my);
    int bi;
    bi = 0;
    b  = 16'hFFFF;
    for (int k = 0; k < 9; k++)
      if (s[k] < b) begin
        b  = s[k];
        bi = k;
      end
    mx = bi % 3 - 1;
    my = bi / 3 - 1;
  endtask

  task automatic run_search(input string name, input logic [8:0][15:0] s, input bit gaps,
                            input int start_at, input logic [15:0] eb,
                            input int ex, input int ey);
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk({name, " busy"}, int'(o_busy), 1);
    chk({name, " init_best"}, int'(o_best_sae), 16'hFFFF);
    for (int k = 0; k < 9; k++) begin
      if (gaps) begin
        i_sae_valid  = 1'b0;
        i_sae_result = 16'h0000;
        @(negedge clk);
      end
      chk({name, " cand_x"}, int'(o_cand_x), k % 3 - 1);
      chk({name, " cand_y"}, int'(o_cand_y), k / 3 - 1);
      i_start      = (k == start_at);
      i_sae_valid  = 1'b1;
      i_sae_result = s[k];
      @(negedge clk);
      i_start = 1'b0;
      if (k < 8) chk({name, " early_done"}, int'(o_done), 0);
    end
    i_sae_valid = 1'b0;
    chk({name, " done"}, int'(o_done), 1);
    chk({name, " busy_in_done"}, int'(o_busy), 0);
    chk({name, " best"}, int'(o_best_sae), int'(eb));
    chk({name, " mv_x"}, int'(o_mv_x), ex);
    chk({name, " mv_y"}, int'(o_mv_y), ey);
    @(negedge clk);
    chk({name, " done_pulse"}, int'(o_done), 0);
    chk({name, " best_hold"}, int'(o_best_sae), int'(eb));
    chk({name, " mv_x_hold"}, int'(o_mv_x), ex);
  endtask

  vec_t vecs [5];

  initial begin
    logic [8:0][15:0] s;
    logic [15:0] eb;
    int ex, ey;

    vecs[0] = '{sae: {16'd50,16'd40,16'd30,16'd20,16'd10,16'd20,16'd30,16'd40,16'd50},
                gaps: 1'b0, start_at: 4'd15, exp_best: 16'd10, exp_x: 8'sd0, exp_y: 8'sd0};
    vecs[1] = '{sae: {16'd9,16'd9,16'd9,16'd9,16'd9,16'd9,16'd7,16'd9,16'd7},
                gaps: 1'b0, start_at: 4'd15, exp_best: 16'd7, exp_x: -8'sd1, exp_y: -8'sd1};
    vecs[2] = '{sae: {16'd1,16'd2,16'd3,16'd4,16'd5,16'd6,16'd7,16'd8,16'd9},
                gaps: 1'b1, start_at: 4'd15, exp_best: 16'd1, exp_x: 8'sd1, exp_y: 8'sd1};
    vecs[3] = '{sae: {9{16'hFFFF}},
                gaps: 1'b0, start_at: 4'd3, exp_best: 16'hFFFF, exp_x: -8'sd1, exp_y: -8'sd1};
    // packed index 0 is the first beat: min 0 at beat 6 -> (-1,+1), later 0s are ties
    vecs[4] = '{sae: {16'd0,16'd5,16'd0,16'd2,16'd3,16'd3,16'd3,16'd3,16'd3},
                gaps: 1'b1, start_at: 4'd7, exp_best: 16'd0, exp_x: -8'sd1, exp_y: 8'sd1};

    rst = 1'b1; i_start = 1'b0; i_sae_valid = 1'b0; i_sae_result = '0;
    repeat (2) @(negedge clk);
    chk("rst busy", int'(o_busy), 0);
    chk("rst done", int'(o_done), 0);
    chk("rst best", int'(o_best_sae), 0);
    chk("rst cand_x", int'(o_cand_x), 0);
    chk("rst mv_y", int'(o_mv_y), 0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++)
      run_search($sformatf("vec%0d", v), vecs[v].sae, vecs[v].gaps, int'(vecs[v].start_at),
                 vecs[v].exp_best, int'(vecs[v].exp_x), int'(vecs[v].exp_y));

    // valid beats in IDLE must not disturb the held result
    for (int k = 0; k < 3; k++) begin
      i_sae_valid = 1'b1; i_sae_result = 16'd0;
      @(negedge clk);
      chk("idle_valid busy", int'(o_busy), 0);
      chk("idle_valid best", int'(o_best_sae), 0);
      chk("idle_valid mv_y", int'(o_mv_y), 1);
    end
    i_sae_valid = 1'b0;

    // reset after 4 beats discards the search
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_sae_valid = 1'b1; i_sae_result = 16'(20 - k);
      @(negedge clk);
    end
    i_sae_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", int'(o_busy), 0);
    chk("midrst done", int'(o_done), 0);
    chk("midrst best", int'(o_best_sae), 0);
    chk("midrst mv_x", int'(o_mv_x), 0);
    chk("midrst mv_y", int'(o_mv_y), 0);
    chk("midrst cand_x", int'(o_cand_x), 0);
    chk("midrst cand_y", int'(o_cand_y), 0);
    for (int k = 0; k < 3; k++) begin
      i_sae_valid = 1'b1; i_sae_result = 16'd1;
      @(negedge clk);
      chk("post_rst idle busy", int'(o_busy), 0);
      chk("post_rst idle best", int'(o_best_sae), 0);
    end
    i_sae_valid = 1'b0;
    s = {16'd1,16'd2,16'd3,16'd4,16'd5,16'd6,16'd7,16'd8,16'd9};
    run_search("after_rst", s, 1'b0, -1, 16'd1, 1, 1);

    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < 9; k++)
        s[k] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 20));
      model(s, eb, ex, ey);
      run_search($sformatf("rand%0d", r), s, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 12)), eb, ex, ey);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
